// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div front-end: accepts one request at a time, issues it to the
// iterative multiplier or divider, and returns the selected 32-bit result.
module imuldiv_muldiv_dispatch #(
  parameter logic [31:0] p_illegal_result = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [31:0] muldivresp_msg_result,
  output logic        muldivresp_msg_illegal,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  fn_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] result_reg;
  logic        illegal_reg;

  logic        is_mul;
  logic        is_div;
  logic        is_rem;
  logic        req_illegal;

  // Unit selection is decoded from the registered fn only, so unit-side
  // handshakes never depend combinationally on the incoming request.
  assign is_mul      = (fn_reg == 3'd0) || (fn_reg == 3'd1);
  assign is_div      = (fn_reg >= 3'd2) && (fn_reg <= 3'd5);
  assign is_rem      = (fn_reg == 3'd4) || (fn_reg == 3'd5);
  assign req_illegal = (muldivreq_msg_fn >= 3'd6);

  assign mulreq_msg_a          = a_reg;
  assign mulreq_msg_b          = b_reg;
  assign divreq_msg_a          = a_reg;
  assign divreq_msg_b          = b_reg;
  assign divreq_msg_fn         = (fn_reg == 3'd2) || (fn_reg == 3'd4);
  assign muldivresp_msg_result = result_reg;
  assign muldivresp_msg_illegal = illegal_reg;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture in IDLE, result capture in WAIT, illegal flag cleared on hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_reg      <= 3'd0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      result_reg  <= 32'd0;
      illegal_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (muldivreq_val) begin
            fn_reg <= muldivreq_msg_fn;
            a_reg  <= muldivreq_msg_a;
            b_reg  <= muldivreq_msg_b;
            if (req_illegal) begin
              result_reg  <= p_illegal_result;
              illegal_reg <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (is_mul && mulresp_val) begin
            result_reg <= (fn_reg == 3'd1) ? mulresp_msg_result[63:32]
                                           : mulresp_msg_result[31:0];
          end else if (is_div && divresp_val) begin
            result_reg <= is_rem ? divresp_msg_result[63:32]
                                 : divresp_msg_result[31:0];
          end
        end
        RESP: begin
          if (muldivresp_rdy) begin
            illegal_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and handshake decode; only the selected unit ever sees val or rdy.
  always_comb begin
    state_next     = state;
    muldivreq_rdy  = 1'b0;
    muldivresp_val = 1'b0;
    mulreq_val     = 1'b0;
    mulresp_rdy    = 1'b0;
    divreq_val     = 1'b0;
    divresp_rdy    = 1'b0;
    case (state)
      IDLE: begin
        muldivreq_rdy = 1'b1;
        if (muldivreq_val) begin
          state_next = req_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (is_mul) begin
          mulreq_val = 1'b1;
          if (mulreq_rdy) begin
            state_next = WAIT;
          end
        end else if (is_div) begin
          divreq_val = 1'b1;
          if (divreq_rdy) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (is_mul) begin
          mulresp_rdy = 1'b1;
          if (mulresp_val) begin
            state_next = RESP;
          end
        end else if (is_div) begin
          divresp_rdy = 1'b1;
          if (divresp_val) begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        muldivresp_val = 1'b1;
        if (muldivresp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Scoreboard bench for the mul/div dispatcher with behavioural unit stubs.
module tb_imuldiv_muldiv_dispatch;

  localparam logic [31:0] ILLEGAL_RES = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  muldivreq_msg_fn = 3'd0;
  logic [31:0] muldivreq_msg_a = 32'd0;
  logic [31:0] muldivreq_msg_b = 32'd0;
  logic        muldivreq_val = 1'b0;
  logic        muldivreq_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_msg_illegal;
  logic        muldivresp_val;
  logic        muldivresp_rdy = 1'b0;
  logic [31:0] mulreq_msg_a;
  logic [31:0] mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy = 1'b0;
  logic [63:0] mulresp_msg_result = 64'd0;
  logic        mulresp_val = 1'b0;
  logic        mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy = 1'b0;
  logic [63:0] divresp_msg_result = 64'd0;
  logic        divresp_val = 1'b0;
  logic        divresp_rdy;

  imuldiv_muldiv_dispatch #(.p_illegal_result(ILLEGAL_RES)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_msg_illegal(muldivresp_msg_illegal),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val),
    .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] res;
    logic        ill;
    int          acc;
    int          bp;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Main-process controls read by the stubs and monitor
  int         mul_lat = 2;
  int         div_lat = 2;
  int         m_stall_end = 0;
  int         next_bp = 0;
  int         issued_cnt = 0;
  int         aband_cnt = 0;
  logic [2:0] cur_fn = 3'd0;

  // Monitor-owned state
  int          done_cnt = 0;
  logic        seen = 1'b0;
  int          hold = 0;
  logic [31:0] held_res = 32'd0;
  logic        held_ill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the architectural result straight from the function definitions
  function automatic logic [31:0] refModel(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    int     sa;
    int     sb;
    longint p;
    logic [31:0] r;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    case (fn)
      3'd0:    r = a * b;
      3'd1:    r = p[63:32];
      3'd2:    r = sa / sb;
      3'd3:    r = a / b;
      3'd4:    r = sa % sb;
      3'd5:    r = a % b;
      default: r = ILLEGAL_RES;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stub: random accept, fixed latency, noise on resp_val while idle
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_prod = 64'd0;
  always @(posedge clk) begin
    if (reset) begin
      m_busy      <= 1'b0;
      mulreq_rdy  <= 1'b0;
      mulresp_val <= 1'b0;
    end else if (!m_busy) begin
      if (mulreq_val && mulreq_rdy) begin
        m_busy      <= 1'b1;
        m_cnt       <= mul_lat;
        m_prod      <= longint'($signed(mulreq_msg_a)) * longint'($signed(mulreq_msg_b));
        mulreq_rdy  <= 1'b0;
        mulresp_val <= 1'b0;
      end else begin
        mulreq_rdy         <= (cyc < m_stall_end) ? 1'b0 : ($urandom_range(0, 2) != 0);
        mulresp_val        <= ($urandom_range(0, 3) == 0);
        mulresp_msg_result <= {$urandom, $urandom};
      end
    end else begin
      if (mulresp_val && mulresp_rdy) begin
        m_busy      <= 1'b0;
        mulresp_val <= 1'b0;
      end else if (m_cnt == 0) begin
        mulresp_val        <= 1'b1;
        mulresp_msg_result <= m_prod;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Divider stub: signedness taken from divreq_msg_fn, returns {rem, quot}
  logic        d_busy = 1'b0;
  int          d_cnt = 0;
  logic [63:0] d_res = 64'd0;
  always @(posedge clk) begin
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = divreq_msg_a;
    sb = divreq_msg_b;
    if (divreq_msg_fn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = divreq_msg_a / divreq_msg_b;
      r = divreq_msg_a % divreq_msg_b;
    end
    if (reset) begin
      d_busy      <= 1'b0;
      divreq_rdy  <= 1'b0;
      divresp_val <= 1'b0;
    end else if (!d_busy) begin
      if (divreq_val && divreq_rdy) begin
        d_busy      <= 1'b1;
        d_cnt       <= div_lat;
        d_res       <= {r, q};
        divreq_rdy  <= 1'b0;
        divresp_val <= 1'b0;
      end else begin
        divreq_rdy         <= ($urandom_range(0, 2) != 0);
        divresp_val        <= ($urandom_range(0, 3) == 0);
        divresp_msg_result <= {$urandom, $urandom};
      end
    end else begin
      if (divresp_val && divresp_rdy) begin
        d_busy      <= 1'b0;
        divresp_val <= 1'b0;
      end else if (d_cnt == 0) begin
        divresp_val        <= 1'b1;
        divresp_msg_result <= d_res;
      end else begin
        d_cnt <= d_cnt - 1;
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each response
  always @(negedge clk) begin
    logic in_flight;
    logic mul_sel;
    logic div_sel;
    exp_t e;
    in_flight = (issued_cnt != done_cnt + aband_cnt);
    mul_sel   = in_flight && (cur_fn <= 3'd1);
    div_sel   = in_flight && (cur_fn >= 3'd2) && (cur_fn <= 3'd5);
    if (reset) begin
      seen           = 1'b0;
      muldivresp_rdy = 1'b0;
    end else begin
      if (in_flight) checkOutput("req_rdy_busy", {63'd0, muldivreq_rdy}, 64'd0);
      if (mulreq_val) checkOutput("mulreq_val_sel", {63'd0, mul_sel}, 64'd1);
      if (mulresp_rdy) checkOutput("mulresp_rdy_sel", {63'd0, mul_sel}, 64'd1);
      if (divreq_val) begin
        checkOutput("divreq_val_sel", {63'd0, div_sel}, 64'd1);
        checkOutput("divreq_fn", {63'd0, divreq_msg_fn},
                    {63'd0, (cur_fn == 3'd2) || (cur_fn == 3'd4)});
      end
      if (divresp_rdy) checkOutput("divresp_rdy_sel", {63'd0, div_sel}, 64'd1);
      if (muldivresp_val) begin
        if (!seen) begin
          seen = 1'b1;
          held_res = muldivresp_msg_result;
          held_ill = muldivresp_msg_illegal;
          hold = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_resp: got result %h, expected no response", muldivresp_msg_result);
          end else begin
            e = exp_q.pop_front();
            hold = e.bp;
            checkOutput("result", {32'd0, muldivresp_msg_result}, {32'd0, e.res});
            checkOutput("illegal", {63'd0, muldivresp_msg_illegal}, {63'd0, e.ill});
            if (e.ill) checkOutput("illegal_latency", 64'(cyc - e.acc), 64'd1);
          end
        end else begin
          checkOutput("result_stable", {32'd0, muldivresp_msg_result}, {32'd0, held_res});
          checkOutput("illegal_stable", {63'd0, muldivresp_msg_illegal}, {63'd0, held_ill});
        end
        if (hold > 0) begin
          muldivresp_rdy = 1'b0;
          hold--;
        end else begin
          muldivresp_rdy = ($urandom_range(0, 3) != 0);
        end
        if (muldivresp_rdy) begin
          seen = 1'b0;
          done_cnt++;
        end
      end else begin
        muldivresp_rdy = $urandom_range(0, 1);
      end
    end
  end

  // Present one request, hold it until accepted, and log the expected response
  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   waited;
    @(negedge clk);
    muldivreq_val    = 1'b1;
    muldivreq_msg_fn = fn;
    muldivreq_msg_a  = a;
    muldivreq_msg_b  = b;
    waited = 0;
    while (!muldivreq_rdy && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!muldivreq_rdy) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got rdy=0, expected rdy=1 within 2000 cycles");
      muldivreq_val = 1'b0;
    end else begin
      e.fn  = fn;
      e.res = refModel(fn, a, b);
      e.ill = (fn >= 3'd6);
      e.acc = cyc;
      e.bp  = next_bp;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cur_fn = fn;
      issued_cnt++;
      muldivreq_val    = 1'b0;
      muldivreq_msg_fn = 3'($urandom);
      muldivreq_msg_a  = $urandom;
      muldivreq_msg_b  = $urandom;
    end
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    while ((issued_cnt != done_cnt + aband_cnt || exp_q.size() != 0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (issued_cnt != done_cnt + aband_cnt || exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    int          waited;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_rdy",   {63'd0, muldivreq_rdy},  64'd1);
    checkOutput("rst_resp_val",  {63'd0, muldivresp_val}, 64'd0);
    checkOutput("rst_mulreq_val", {63'd0, mulreq_val},    64'd0);
    checkOutput("rst_divreq_val", {63'd0, divreq_val},    64'd0);
    checkOutput("rst_result",    {32'd0, muldivresp_msg_result}, 64'd0);

    // Directed cases from the plan
    mul_lat = 33;
    applyStimulus(3'd0, 32'd5, 32'hFFFF_FFFD);
    waitIdle();
    mul_lat = 2;
    applyStimulus(3'd1, 32'h8000_0000, 32'd2);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(3'd5, 32'd7, 32'd3);
    applyStimulus(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(3'd6, 32'd1, 32'd2);
    waitIdle();

    // Unit stall in ISSUE plus consumer back-pressure in RESP
    next_bp = 5;
    m_stall_end = cyc + 6;
    applyStimulus(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    next_bp = 0;
    waitIdle();

    // Reset while the multiplier is working
    mul_lat = 40;
    applyStimulus(3'd0, 32'd11, 32'd13);
    waited = 0;
    while (!m_busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reset_test_reached_wait", {63'd0, m_busy}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    aband_cnt++;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_req_rdy",  {63'd0, muldivreq_rdy},  64'd1);
    checkOutput("midrst_resp_val", {63'd0, muldivresp_val}, 64'd0);
    checkOutput("midrst_result",   {32'd0, muldivresp_msg_result}, 64'd0);
    mul_lat = 3;
    applyStimulus(3'd0, 32'd6, 32'd7);
    waitIdle();

    // Randomized traffic across all function codes
    for (int i = 0; i < 60; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (b == 32'd0) b = 32'd1;
      if ((fn == 3'd2 || fn == 3'd4) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      mul_lat = $urandom_range(0, 6);
      div_lat = $urandom_range(0, 6);
      next_bp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
      applyStimulus(fn, a, b);
    end
    next_bp = 0;
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
